// File: rtl/bcd_timekeeper.sv
// BCD HH:MM:SS timekeeper with a CLK_HZ prescaler, load and per-field manual increments.
// Optional feature: define BCD_TIMEKEEPER_LOAD_CHECK_EN to reject loads holding
// non-BCD or out-of-range fields (load_err pulses instead of loading).
module bcd_timekeeper #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        load,
    input  logic [23:0] time_in,
    input  logic        inc_sec,
    input  logic        inc_min,
    input  logic        inc_hr,
    output logic [23:0] time_out,
    output logic        sec_pulse,
    output logic        day_pulse,
    output logic        load_err
);

    localparam int unsigned CntW = $clog2(CLK_HZ);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [23:0]     time_q, time_d;
    logic            sec_pulse_q, sec_pulse_d;
    logic            day_pulse_q, day_pulse_d;
    logic            load_err_q, load_err_d;

    logic            tick;
    logic            inc_any;
    logic            inc_one;
    logic            load_ok;
    logic [8:0]      sec_nxt;
    logic [8:0]      min_nxt;

    // Minutes/seconds field is legal when tens <= 5 and units <= 9.
    function automatic logic valid60(input logic [7:0] f);
        return (f[7:4] <= 4'd5) && (f[3:0] <= 4'd9);
    endfunction

    // Hours field is legal for 00..23.
    function automatic logic valid_hr(input logic [7:0] f);
        return (f[3:0] <= 4'd9) && ((f[7:4] < 4'd2) || ((f[7:4] == 4'd2) && (f[3:0] <= 4'd3)));
    endfunction

    // Returns {carry, next}; an illegal field is treated like 59 (goes to 00 with carry).
    function automatic logic [8:0] inc60(input logic [7:0] f);
        logic [8:0] r;
        if (!valid60(f) || (f == 8'h59)) begin
            r = {1'b1, 8'h00};
        end else if (f[3:0] == 4'd9) begin
            r = {1'b0, f[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, f[7:4], f[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] inc_hours(input logic [7:0] f);
        logic [7:0] r;
        if (!valid_hr(f) || (f == 8'h23)) begin
            r = 8'h00;
        end else if (f[3:0] == 4'd9) begin
            r = {f[7:4] + 4'd1, 4'd0};
        end else begin
            r = {f[7:4], f[3:0] + 4'd1};
        end
        return r;
    endfunction

`ifdef BCD_TIMEKEEPER_LOAD_CHECK_EN
    assign load_ok = valid60(time_in[7:0]) && valid60(time_in[15:8]) && valid_hr(time_in[23:16]);
`else
    assign load_ok = 1'b1;
`endif

    assign tick    = run && (cnt_q == CntMax);
    assign inc_any = inc_sec | inc_min | inc_hr;
    // Exactly one strobe: odd parity but not all three.
    assign inc_one = (inc_sec ^ inc_min ^ inc_hr) & ~(inc_sec & inc_min & inc_hr);

    // Next-state: prescaler, time fields and strobes under load > inc > tick priority.
    always_comb begin
        cnt_d       = cnt_q;
        time_d      = time_q;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        load_err_d  = 1'b0;
        sec_nxt     = inc60(time_q[7:0]);
        min_nxt     = inc60(time_q[15:8]);

        if (run) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end

        if (load) begin
            if (load_ok) begin
                time_d = time_in;
                cnt_d  = '0;
            end else begin
                // Rejected load freezes the prescaler too; any coincident tick is dropped.
                cnt_d      = cnt_q;
                load_err_d = 1'b1;
            end
        end else if (inc_any) begin
            // Any inc strobe claims the cycle; conflicting strobes apply nothing.
            if (inc_one) begin
                unique case ({inc_hr, inc_min, inc_sec})
                    3'b001:  time_d[7:0]   = sec_nxt[7:0];
                    3'b010:  time_d[15:8]  = min_nxt[7:0];
                    3'b100:  time_d[23:16] = inc_hours(time_q[23:16]);
                    default: time_d = time_q;
                endcase
            end
        end else if (tick) begin
            time_d[7:0] = sec_nxt[7:0];
            if (sec_nxt[8]) begin
                time_d[15:8] = min_nxt[7:0];
                if (min_nxt[8]) begin
                    time_d[23:16] = inc_hours(time_q[23:16]);
                end
            end
            sec_pulse_d = 1'b1;
            day_pulse_d = (time_d == 24'h000000);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            time_q      <= 24'h000000;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            time_q      <= time_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
            load_err_q  <= load_err_d;
        end
    end

    assign time_out  = time_q;
    assign sec_pulse = sec_pulse_q;
    assign day_pulse = day_pulse_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Self-checking bench for bcd_timekeeper at CLK_HZ=10: a per-cycle vector table
// for load/inc behaviour (run=0) plus hand-written multi-cycle timing sequences.
module tb_bcd_timekeeper;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        load = 1'b0;
    logic [23:0] time_in = 24'h0;
    logic        inc_sec = 1'b0;
    logic        inc_min = 1'b0;
    logic        inc_hr = 1'b0;
    logic [23:0] time_out;
    logic        sec_pulse;
    logic        day_pulse;
    logic        load_err;

    int n_checks = 0;
    int n_fail = 0;

`ifdef BCD_TIMEKEEPER_LOAD_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    bcd_timekeeper #(.CLK_HZ(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .load      (load),
        .time_in   (time_in),
        .inc_sec   (inc_sec),
        .inc_min   (inc_min),
        .inc_hr    (inc_hr),
        .time_out  (time_out),
        .sec_pulse (sec_pulse),
        .day_pulse (day_pulse),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [23:0] tin;
        logic [2:0]  inc;   // {hr, min, sec}
        logic [23:0] et;
        logic        es;
        logic        ed;
        logic        ee;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic ld, input logic [23:0] tin,
                                input logic [2:0] inc, input logic [23:0] et,
                                input logic ee);
        vec_t v;
        v.rst = rst; v.ld = ld; v.tin = tin; v.inc = inc;
        v.et = et; v.es = 1'b0; v.ed = 1'b0; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic r, input logic ru, input logic l, input logic [23:0] t,
                        input logic [2:0] inc);
        @(negedge clk);
        reset = r; run = ru; load = l; time_in = t;
        inc_hr = inc[2]; inc_min = inc[1]; inc_sec = inc[0];
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pulses(input string nm, input logic es, input logic ed);
        chk({nm, ".sec_pulse"}, {23'h0, sec_pulse}, {23'h0, es});
        chk({nm, ".day_pulse"}, {23'h0, day_pulse}, {23'h0, ed});
    endtask

    initial begin
        // Per-cycle table, run=0 so the prescaler never ticks.
        vecs.push_back(mk(1, 0, 24'h000000, 3'b000, 24'h000000, 0));
        vecs.push_back(mk(0, 1, 24'h125959, 3'b000, 24'h125959, 0));
        vecs.push_back(mk(0, 0, 24'h000000, 3'b001, 24'h125900, 0));
        vecs.push_back(mk(0, 0, 24'h000000, 3'b010, 24'h120000, 0));
        vecs.push_back(mk(0, 0, 24'h000000, 3'b100, 24'h130000, 0));
        vecs.push_back(mk(0, 1, 24'h235959, 3'b000, 24'h235959, 0));
        vecs.push_back(mk(0, 0, 24'h000000, 3'b100, 24'h005959, 0));
        vecs.push_back(mk(0, 0, 24'h000000, 3'b011, 24'h005959, 0));
        vecs.push_back(mk(0, 0, 24'h000000, 3'b111, 24'h005959, 0));
        vecs.push_back(mk(0, 1, 24'h246000, 3'b000, ChkEn ? 24'h005959 : 24'h246000, ChkEn));
        vecs.push_back(mk(0, 1, 24'h120000, 3'b000, 24'h120000, 0));
        vecs.push_back(mk(0, 0, 24'h000000, 3'b010, 24'h120100, 0));
        vecs.push_back(mk(1, 1, 24'h999999, 3'b001, 24'h000000, 0));
        vecs.push_back(mk(0, 1, 24'h010203, 3'b001, 24'h010203, 0));
        vecs.push_back(mk(0, 0, 24'h000000, 3'b100, 24'h020203, 0));
        vecs.push_back(mk(0, 1, 24'h000059, 3'b000, 24'h000059, 0));
        vecs.push_back(mk(0, 0, 24'h000000, 3'b001, 24'h000000, 0));
        vecs.push_back(mk(0, 0, 24'h000000, 3'b101, 24'h000000, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, 1'b0, vecs[i].ld, vecs[i].tin, vecs[i].inc);
            chk($sformatf("vec%0d.time", i), time_out, vecs[i].et);
            chk_pulses($sformatf("vec%0d", i), vecs[i].es, vecs[i].ed);
            chk($sformatf("vec%0d.load_err", i), {23'h0, load_err}, {23'h0, vecs[i].ee});
        end

`ifndef BCD_TIMEKEEPER_LOAD_CHECK_EN
        // Illegal fields roll to 00 on their next increment.
        step(0, 0, 1, 24'h2A5F7B, 3'b000);
        chk("bad.load", time_out, 24'h2A5F7B);
        step(0, 0, 0, 24'h0, 3'b001);
        chk("bad.sec", time_out, 24'h2A5F00);
        step(0, 0, 0, 24'h0, 3'b010);
        chk("bad.min", time_out, 24'h2A0000);
        step(0, 0, 0, 24'h0, 3'b100);
        chk("bad.hr", time_out, 24'h000000);
`endif

        // From reset: first second after 10 cycles, one minute after 600.
        step(1, 0, 0, 24'h0, 3'b000);
        chk("rst.time", time_out, 24'h000000);
        for (int i = 1; i <= 600; i++) begin
            step(0, 1, 0, 24'h0, 3'b000);
            chk_pulses($sformatf("run%0d", i), (i % 10) == 0, 1'b0);
            if (i == 10) chk("run10.time", time_out, 24'h000001);
            if (i == 600) chk("run600.time", time_out, 24'h000100);
        end

        // Midnight rollover.
        step(0, 1, 1, 24'h235958, 3'b000);
        chk("mid.load", time_out, 24'h235958);
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 0, 24'h0, 3'b000);
            chk_pulses($sformatf("mid%0d", i), (i % 10) == 0, i == 20);
            if (i == 10) chk("mid10.time", time_out, 24'h235959);
            if (i == 20) chk("mid20.time", time_out, 24'h000000);
        end

        // Load coincident with a tick: loaded value, no advance, prescaler restarts.
        step(0, 1, 1, 24'h101010, 3'b000);
        for (int i = 1; i <= 9; i++) begin
            step(0, 1, 0, 24'h0, 3'b000);
            chk_pulses($sformatf("pre%0d", i), 1'b0, 1'b0);
        end
        step(0, 1, 1, 24'h111111, 3'b000);
        chk("ldtick.time", time_out, 24'h111111);
        chk_pulses("ldtick", 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 0, 24'h0, 3'b000);
            chk_pulses($sformatf("post%0d", i), i == 10, 1'b0);
        end
        chk("post10.time", time_out, 24'h111112);

        // run=0 freezes the prescaler mid-count.
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 24'h0, 3'b000);
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 0, 24'h0, 3'b000);
            chk_pulses($sformatf("hold%0d", i), 1'b0, 1'b0);
        end
        chk("hold.time", time_out, 24'h111112);
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 0, 24'h0, 3'b000);
            chk_pulses($sformatf("resume%0d", i), i == 5, 1'b0);
        end
        chk("resume.time", time_out, 24'h111113);

        // Reset at prescaler count 7 wins over load/inc; next tick 10 cycles after release.
        step(0, 1, 1, 24'h123456, 3'b000);
        for (int i = 1; i <= 7; i++) step(0, 1, 0, 24'h0, 3'b000);
        step(1, 1, 1, 24'h999999, 3'b001);
        chk("rst7.time", time_out, 24'h000000);
        chk_pulses("rst7", 1'b0, 1'b0);
        chk("rst7.load_err", {23'h0, load_err}, 24'h0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 0, 24'h0, 3'b000);
            chk_pulses($sformatf("rel%0d", i), i == 10, 1'b0);
        end
        chk("rel10.time", time_out, 24'h000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_timekeeper.md
BCD_TIMEKEEPER -- requirements
Module: bcd_timekeeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning input clock frequency and prescaler terminal count (minimum 2).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port run  input  1  1 = timekeeping advances; 0 = hold (set mode).
REQ-005 SHALL have port load  input  1  one-cycle strobe to load time_in.
REQ-006 SHALL have port time_in  input  24  BCD HHMMSS value to load.
REQ-007 SHALL have ports inc_sec, inc_min, inc_hr  input  1 each  one-cycle field-increment strobes.
REQ-008 SHALL have port time_out  output  24  registered BCD HHMMSS: [23:20] H tens, [19:16] H units, [15:12] M tens, [11:8] M units, [7:4] S tens, [3:0] S units.
REQ-009 SHALL have port sec_pulse  output  1  one-cycle strobe on every automatic seconds advance.
REQ-010 SHALL have port day_pulse  output  1  one-cycle strobe on the 23:59:59 -> 00:00:00 advance.
REQ-011 SHALL have port load_err  output  1  one-cycle strobe on a rejected load (macro-dependent).

Function
REQ-012 SHALL hold a prescaler counting 0..CLK_HZ-1 while run=1; on reaching CLK_HZ-1 it SHALL wrap to 0 and generate an internal tick that same cycle.
REQ-013 SHALL freeze the prescaler at its current value while run=0, and clear it to 0 on any accepted load.
REQ-014 On a tick, SHALL advance time_out by one second, with results visible on the next clock edge (1-cycle latency).
REQ-015 Seconds SHALL carry 59->00 into minutes, and minutes 59->00 into hours; hours SHALL wrap 23->00. Unit digits SHALL roll 9->0 with tens+1.
REQ-016 SHALL assert sec_pulse for exactly the cycle time_out shows the advanced value; SHALL assert day_pulse in the same cycle only when the new value is 00:00:00 from a tick.
REQ-017 inc_sec SHALL increment seconds only (59->00, no carry into minutes); inc_min likewise for minutes; inc_hr SHALL wrap 23->00 with no day_pulse.
REQ-018 Manual increments SHALL be accepted regardless of run, and SHALL NOT assert sec_pulse.
REQ-019 If more than one inc_* is high in the same cycle, SHALL apply none of them.
REQ-020 Priority per cycle SHALL be reset > load > inc_* > tick; a lower-priority event coinciding with a higher one SHALL be discarded, not deferred.
REQ-021 An accepted load SHALL place time_in on time_out at the next edge.
REQ-022 Arithmetic SHALL be performed per BCD field; any field already holding a non-BCD or out-of-range value SHALL, on its next increment, become 00 (hours 00) with normal carry where applicable.

Reset
REQ-023 On reset=1 at a clock edge, SHALL set time_out=24'h000000, sec_pulse=0, day_pulse=0, load_err=0, prescaler=0.
REQ-024 Reset asserted mid-count or coincident with load/inc/tick SHALL win; the first tick after release SHALL occur CLK_HZ cycles after the first edge with reset=0 and run=1.

Configuration
REQ-025 With macro BCD_TIMEKEEPER_LOAD_CHECK_EN defined, a load whose time_in has any digit >9, seconds or minutes >59, or hours >23 SHALL be rejected: time_out and prescaler unchanged, load_err=1 for one cycle.
REQ-026 Without BCD_TIMEKEEPER_LOAD_CHECK_EN, every load SHALL be accepted verbatim and load_err SHALL be tied to 0.

Verification (CLK_HZ=10)
REQ-027 Reset, run=1, 10 cycles -> time_out 00:00:01 with one sec_pulse; after 600 cycles total -> 00:01:00.
REQ-028 load time_in=24'h235958, run=1, 20 cycles -> 23:59:59 then 00:00:00 with day_pulse and sec_pulse both high for one cycle.
REQ-029 time_out=12:59:59, run=0, inc_sec strobe -> 12:59:00; inc_min -> 12:00:00; inc_hr at 23:xx:xx -> 00:xx:xx; no pulses.
REQ-030 inc_sec and inc_min high together -> time_out unchanged; load coincident with tick -> loaded value, no advance, prescaler 0.
REQ-031 With macro: load 24'h246000 -> time_out unchanged, load_err pulse; without macro -> time_out=24'h246000, load_err=0.
REQ-032 reset asserted at prescaler count 7 -> all outputs zero next edge; next tick exactly 10 cycles after reset release.
